reg_writeback_unit: RTL and testbench

- Writeback stage; drives the register file write port (write_en / write_addr / write_value) that the decode-stage register file consumes.
- Accepts one retiring instruction per cycle from execute and selects the result source: ALU, load data, PC+4 or CSR.
- Loads run a memory response handshake with a timeout counter; upstream is stalled while a load is outstanding.

---
 rtl/reg_writeback_unit_if.sv | 52 +++++
 rtl/reg_writeback_unit.sv | 155 +++++++++++++++
 tb/tb_reg_writeback_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_unit_if.sv
// Purpose : bundles the execute-result, load-response and register-file write
//           signals of reg_writeback_unit into one interface.
// Ports   : slave = the writeback unit; master = execute/memory/regfile side.
// Latency : n/a (wiring only).
// Config  : WB_BYPASS_EN adds fwd_valid / fwd_addr / fwd_data.
interface reg_writeback_unit_if #(
  parameter int XLEN = 32
);
  // execute -> writeback
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic            in_rf_wen;
  logic [1:0]      in_wb_sel;
  logic [XLEN-1:0] in_alu_out;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_csr_rdata;
  logic [2:0]      in_funct3;
  logic [1:0]      in_addr_lo;
  // load response handshake
  logic            mem_req;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  // register file write port
  logic            write_en;
  logic [4:0]      write_addr;
  logic [XLEN-1:0] write_value;
  logic            timeout_err;
`ifdef WB_BYPASS_EN
  logic            fwd_valid;
  logic [4:0]      fwd_addr;
  logic [XLEN-1:0] fwd_data;
`endif

  modport slave (
    input  in_valid, in_rd, in_rf_wen, in_wb_sel, in_alu_out, in_pc,
           in_csr_rdata, in_funct3, in_addr_lo, mem_ack, mem_rdata,
    output in_ready, mem_req, write_en, write_addr, write_value, timeout_err
`ifdef WB_BYPASS_EN
    , output fwd_valid, fwd_addr, fwd_data
`endif
  );

  modport master (
    output in_valid, in_rd, in_rf_wen, in_wb_sel, in_alu_out, in_pc,
           in_csr_rdata, in_funct3, in_addr_lo, mem_ack, mem_rdata,
    input  in_ready, mem_req, write_en, write_addr, write_value, timeout_err
`ifdef WB_BYPASS_EN
    , input fwd_valid, fwd_addr, fwd_data
`endif
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// Purpose : writeback stage; picks ALU / load / PC+4 / CSR result and drives the
//           register file write port. Ports: clk, rst (sync, active high), bus.
// Latency : 1 cycle for non-load results; loads write 1 cycle after mem_ack.
// Backpr. : in_ready low while a load waits for mem_ack (abandoned after
//           TIMEOUT_CYCLES, raising sticky timeout_err).
// Config  : define WB_BYPASS_EN for the fwd_* decode-forwarding outputs.
module reg_writeback_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_writeback_unit_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;
  localparam logic [1:0] SEL_CSR = 2'b11;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic            rf_wen_q, rf_wen_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic            wen_q, wen_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wval_q, wval_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] exec_val;
  logic [XLEN-1:0] load_val;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  // Byte/halfword lanes of the aligned load word; halfword ignores addr_lo[0].
  assign ld_byte = bus.mem_rdata[{addr_lo_q, 3'b000} +: 8];
  assign ld_half = bus.mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = bus.mem_rdata;
    case (funct3_q)
      3'b000:  load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, ld_half};
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    exec_val = bus.in_alu_out;
    case (bus.in_wb_sel)
      SEL_PC4: exec_val = bus.in_pc + XLEN'(4);
      SEL_CSR: exec_val = bus.in_csr_rdata;
      default: exec_val = bus.in_alu_out;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    rf_wen_d  = rf_wen_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wval_d    = wval_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        // in_ready is high in IDLE, so in_valid alone means accept.
        // mem_ack is deliberately ignored here (late acks after a timeout).
        if (bus.in_valid) begin
          rd_d      = bus.in_rd;
          rf_wen_d  = bus.in_rf_wen;
          funct3_d  = bus.in_funct3;
          addr_lo_d = bus.in_addr_lo;
          if (bus.in_wb_sel == SEL_MEM) begin
            // Enter the handshake even for rd=0 / rf_wen=0 so memory sees it complete.
            state_d = WAIT_MEM;
            cnt_d   = '0;
          end else begin
            wen_d   = bus.in_rf_wen && (bus.in_rd != 5'd0);
            waddr_d = bus.in_rd;
            wval_d  = exec_val;
          end
        end
      end
      WAIT_MEM: begin
        // An ack in the threshold cycle takes priority over the timeout.
        if (bus.mem_ack) begin
          wen_d   = rf_wen_q && (rd_q != 5'd0);
          waddr_d = rd_q;
          wval_d  = load_val;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      rf_wen_q  <= 1'b0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wval_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      rf_wen_q  <= rf_wen_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wval_q    <= wval_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.mem_req     = (state_q == WAIT_MEM);
  assign bus.write_en    = wen_q;
  assign bus.write_addr  = waddr_q;
  assign bus.write_value = wval_q;
  assign bus.timeout_err = err_q;

`ifdef WB_BYPASS_EN
  // Forward exactly what the write port will register at the next edge.
  assign bus.fwd_valid = wen_d && !rst;
  assign bus.fwd_addr  = waddr_d;
  assign bus.fwd_data  = wval_d;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
module tb_reg_writeback_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int pushes = 0;
  int writes = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  reg_writeback_unit_if #(.XLEN(32)) bus ();

  reg_writeback_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every write_en pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.write_en === 1'b1) begin
      writes++;
      if (sb_q.size() == 0) begin
        chk("unexpected_write", 32'(bus.write_addr), 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        chk("write_addr", 32'(bus.write_addr), 32'(e[36:32]));
        chk("write_value", bus.write_value, e[31:0]);
      end
    end
  end

  task automatic push(input logic [4:0] rd, input logic [31:0] val);
    sb_q.push_back({rd, val});
    pushes++;
  endtask

  // Drive one non-load instruction for one cycle (in_valid left high).
  task automatic exec(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] pc,
                      input logic [31:0] csr, input logic [31:0] exp);
    bus.in_valid = 1'b1; bus.in_rd = rd; bus.in_rf_wen = wen; bus.in_wb_sel = sel;
    bus.in_alu_out = alu; bus.in_pc = pc; bus.in_csr_rdata = csr;
    chk("exec_in_ready", 32'(bus.in_ready), 32'd1);
    if (wen && rd != 5'd0) push(rd, exp);
    tick();
  endtask

  // Load: accept, `waits` cycles without ack, then ack.
  task automatic do_load(input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                         input logic [1:0] lo, input int waits, input logic [31:0] exp);
    bus.in_valid = 1'b1; bus.in_rd = rd; bus.in_rf_wen = wen; bus.in_wb_sel = 2'b01;
    bus.in_funct3 = f3; bus.in_addr_lo = lo;
    chk("ld_accept_ready", 32'(bus.in_ready), 32'd1);
    if (wen && rd != 5'd0) push(rd, exp);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < waits; i++) begin
      chk("ld_wait_ready", 32'(bus.in_ready), 32'd0);
      chk("ld_wait_memreq", 32'(bus.mem_req), 32'd1);
      tick();
    end
    bus.mem_ack = 1'b1;
    chk("ld_ack_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    chk("ld_done_ready", 32'(bus.in_ready), 32'd1);
    chk("ld_done_memreq", 32'(bus.mem_req), 32'd0);
    chk("ld_done_wen", 32'(bus.write_en), 32'(wen && rd != 5'd0));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wen"}, 32'(bus.write_en), 32'd0);
    chk({tag, "_waddr"}, 32'(bus.write_addr), 32'd0);
    chk({tag, "_wval"}, bus.write_value, 32'd0);
    chk({tag, "_err"}, 32'(bus.timeout_err), 32'd0);
    chk({tag, "_memreq"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_rf_wen = 1'b0; bus.in_wb_sel = '0;
    bus.in_alu_out = '0; bus.in_pc = '0; bus.in_csr_rdata = '0; bus.in_funct3 = '0;
    bus.in_addr_lo = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk_reset_state("reset");
    rst = 1'b0;
    tick();

    // Back-to-back ALU writes
    exec(5'd5, 1'b1, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234);
    exec(5'd6, 1'b1, 2'b00, 32'h0000_BEEF, 32'h0, 32'h0, 32'h0000_BEEF);
    bus.in_valid = 1'b0;
    chk("alu2_wen", 32'(bus.write_en), 32'd1);
    chk("alu2_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("alu_idle_wen", 32'(bus.write_en), 32'd0);

    // PC+4 wrap, then x0 destination (no write expected)
    exec(5'd1, 1'b1, 2'b10, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000);
    exec(5'd0, 1'b1, 2'b10, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000);
    bus.in_valid = 1'b0;
    chk("x0_wen", 32'(bus.write_en), 32'd0);
    // rf_wen=0 CSR op: no write
    exec(5'd9, 1'b0, 2'b11, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0);
    bus.in_valid = 1'b0;
    chk("nowen_wen", 32'(bus.write_en), 32'd0);
    tick();

    // Loads from 0x80FF7F01
    bus.mem_rdata = 32'h80FF_7F01;
    do_load(5'd7, 1'b1, 3'b000, 2'd3, 2, 32'hFFFF_FF80); // LB
    do_load(5'd8, 1'b1, 3'b100, 2'd2, 0, 32'h0000_00FF); // LBU
    do_load(5'd9, 1'b1, 3'b001, 2'd2, 1, 32'hFFFF_80FF); // LH
    do_load(5'd10, 1'b1, 3'b101, 2'd1, 0, 32'h0000_7F01); // LHU, addr_lo[0] ignored
    do_load(5'd11, 1'b1, 3'b010, 2'd0, 0, 32'h80FF_7F01); // LW
    do_load(5'd12, 1'b1, 3'b111, 2'd3, 0, 32'h80FF_7F01); // other funct3 -> word
    do_load(5'd13, 1'b1, 3'b000, 2'd1, 0, 32'h0000_007F); // LB positive
    do_load(5'd0, 1'b1, 3'b010, 2'd0, 1, 32'h0);          // rd=0: handshake, no write
    do_load(5'd14, 1'b0, 3'b010, 2'd0, 0, 32'h0);         // rf_wen=0
    // ack in the threshold cycle wins over timeout
    do_load(5'd15, 1'b1, 3'b010, 2'd0, 3, 32'h80FF_7F01);
    chk("thresh_ack_err", 32'(bus.timeout_err), 32'd0);
    tick();

    // Timeout: no ack for 4 WAIT_MEM cycles
    bus.in_valid = 1'b1; bus.in_rd = 5'd16; bus.in_rf_wen = 1'b1; bus.in_wb_sel = 2'b01;
    bus.in_funct3 = 3'b010;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_err", 32'(bus.timeout_err), 32'd0);
      chk("to_wait_memreq", 32'(bus.mem_req), 32'd1);
      tick();
    end
    chk("to_err", 32'(bus.timeout_err), 32'd1);
    chk("to_ready", 32'(bus.in_ready), 32'd1);
    chk("to_memreq", 32'(bus.mem_req), 32'd0);
    chk("to_wen", 32'(bus.write_en), 32'd0);
    bus.mem_ack = 1'b1;  // stray late ack
    tick();
    bus.mem_ack = 1'b0;
    chk("stray_wen", 32'(bus.write_en), 32'd0);
    chk("stray_memreq", 32'(bus.mem_req), 32'd0);
    tick();
    chk("to_sticky", 32'(bus.timeout_err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to_cleared", 32'(bus.timeout_err), 32'd0);

    // Reset in the middle of a load
    bus.in_valid = 1'b1; bus.in_rd = 5'd17; bus.in_rf_wen = 1'b1; bus.in_wb_sel = 2'b01;
    tick();
    bus.in_valid = 1'b0;
    chk("midrst_memreq_pre", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk_reset_state("midrst");
    tick();

`ifdef WB_BYPASS_EN
    chk("fwd_idle", 32'(bus.fwd_valid), 32'd0);
    bus.in_valid = 1'b1; bus.in_rd = 5'd3; bus.in_rf_wen = 1'b1; bus.in_wb_sel = 2'b11;
    bus.in_csr_rdata = 32'h0000_0055;
    #1;
    chk("fwd_valid", 32'(bus.fwd_valid), 32'd1);
    chk("fwd_addr", 32'(bus.fwd_addr), 32'd3);
    chk("fwd_data", bus.fwd_data, 32'h0000_0055);
    push(5'd3, 32'h0000_0055);
    tick();
    bus.in_valid = 1'b0;
    chk("fwd_wen_follow", 32'(bus.write_en), 32'd1);
    bus.in_rd = 5'd18; bus.in_wb_sel = 2'b01; bus.in_funct3 = 3'b000; bus.in_addr_lo = 2'd3;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("fwd_wait_noack", 32'(bus.fwd_valid), 32'd0);
    bus.mem_ack = 1'b1;
    #1;
    chk("fwd_ld_valid", 32'(bus.fwd_valid), 32'd1);
    chk("fwd_ld_data", bus.fwd_data, 32'hFFFF_FF80);
    push(5'd18, 32'hFFFF_FF80);
    tick();
    bus.mem_ack = 1'b0;
    tick();
`endif

    tick(); tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("write_count", 32'(writes), 32'(pushes));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
